// File: rtl/wb_spi_pkg.sv
// Shared constants and FSM encoding for the Wishbone-to-SPI-engine bridge.
package wb_spi_pkg;

  localparam int IF_DIN_W  = 11;
  localparam int IF_DOUT_W = 9;
  localparam int BUSY_BIT  = 8;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_DATA   = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_RESP
  } state_t;

endpackage

// File: rtl/wb_spi_tmo.sv
// Saturating wait-state counter: flags expiry after TO_CYCLES enabled cycles
// since the last clear. Only used when WB_SPI_BRIDGE_TIMEOUT_EN is defined.
module wb_spi_tmo #(
  parameter int TO_CYCLES = 4095,
  parameter int TO_W      = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Count value k means k+1 cycles have been spent in the waiting state.
  assign expired = (cnt == TO_W'(TO_CYCLES - 1));

endmodule

// File: rtl/wb_spi_bridge.sv
// Wishbone classic slave driving the SPI engine's cmd/wr/rd strobe interface.
// Optional bus timeout and error response: define WB_SPI_BRIDGE_TIMEOUT_EN.
module wb_spi_bridge
  import wb_spi_pkg::*;
#(
  parameter int DW        = 32,
  parameter int TO_CYCLES = 4095,
  parameter int TO_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [1:0]           wb_adr_i,
  input  logic [DW-1:0]        wb_dat_i,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [IF_DIN_W-1:0]  if_din,
  output logic                 if_cmd,
  output logic                 if_wr,
  output logic                 if_rd,
  input  logic [IF_DOUT_W-1:0] if_dout,
  input  logic                 if_ack,
  input  logic                 if_irq
);

  if ((64'd1 << TO_W) <= 64'(TO_CYCLES)) begin : g_bad_to_w
    $error("wb_spi_bridge: TO_W too narrow for TO_CYCLES");
  end

  state_t              state, state_nx;
  logic [1:0]          adr_q;
  logic                we_q;
  logic [IF_DIN_W-1:0] dat_q;
  logic [IF_DIN_W-1:0] shadow_q;
  logic                abort_q;
  logic                err_q;
  logic [DW-1:0]       rdat_q;
  logic [DW-1:0]       rd_val;

  logic req, busy, to_hit;
  logic cap_req, cap_rd, imm_resp, err_nx;
  logic unused_dat;

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign busy       = if_dout[BUSY_BIT];
  assign unused_dat = ^wb_dat_i[DW-1:IF_DIN_W];

`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  localparam bit RSV_ERR = 1'b1;
  logic tmo_clr, tmo_en;

  assign tmo_en  = (state == ST_HOLD) || (state == ST_WAIT_ACK);
  assign tmo_clr = (state_nx != state) &&
                   ((state_nx == ST_HOLD) || (state_nx == ST_WAIT_ACK));

  wb_spi_tmo #(
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (TO_W)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (to_hit)
  );
`else
  localparam bit RSV_ERR = 1'b0;
  assign to_hit = 1'b0;
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cap_req  = 1'b0;
    cap_rd   = 1'b0;
    imm_resp = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          cap_req = 1'b1;
          // STATUS is read-only: its writes are answered without bothering the engine.
          if ((wb_adr_i == ADR_RSVD) || (wb_we_i && wb_adr_i == ADR_STATUS)) begin
            state_nx = ST_RESP;
            imm_resp = 1'b1;
            err_nx   = RSV_ERR && (wb_adr_i == ADR_RSVD);
          end else if (wb_we_i && wb_adr_i == ADR_DATA && busy) begin
            state_nx = ST_HOLD;
          end else begin
            state_nx = ST_STROBE;
          end
        end
      end
      ST_HOLD: begin
        if (!wb_cyc_i) begin
          state_nx = ST_IDLE;
        end else if (to_hit) begin
          state_nx = ST_RESP;
          err_nx   = 1'b1;
        end else if (!busy) begin
          state_nx = ST_STROBE;
        end
      end
      ST_STROBE: state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // An abandoned cycle still drains the engine handshake, but is never acked.
        if (if_ack) begin
          cap_rd   = 1'b1;
          state_nx = (abort_q || !wb_cyc_i) ? ST_IDLE : ST_RESP;
        end else if (to_hit) begin
          state_nx = (abort_q || !wb_cyc_i) ? ST_IDLE : ST_RESP;
          err_nx   = 1'b1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (!we_q) begin
      case (adr_q)
        ADR_CTRL:   rd_val[IF_DIN_W-1:0] = shadow_q;
        ADR_DATA:   rd_val[7:0]          = if_dout[7:0];
        ADR_STATUS: rd_val[1:0]          = {if_irq, busy};
        default:    rd_val               = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      shadow_q <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= '0;
    end else begin
      state <= state_nx;
      if (cap_req) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i[IF_DIN_W-1:0];
      end
      if (cap_req) begin
        abort_q <= 1'b0;
      end else if (((state == ST_STROBE) || (state == ST_WAIT_ACK)) && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (state_nx == ST_RESP) begin
        err_q <= err_nx;
      end
      if (imm_resp) begin
        rdat_q <= '0;
      end else if (cap_rd) begin
        rdat_q <= rd_val;
      end
      if (if_cmd) begin
        shadow_q <= dat_q;
      end
    end
  end

  // Moore outputs: decoded only from the state register and latched request.
  assign if_cmd = (state == ST_STROBE) &&  we_q && (adr_q == ADR_CTRL);
  assign if_wr  = (state == ST_STROBE) &&  we_q && (adr_q == ADR_DATA);
  assign if_rd  = (state == ST_STROBE) && !we_q;

  always_comb begin
    if_din = '0;
    if ((state == ST_STROBE) && we_q) begin
      if_din = (adr_q == ADR_CTRL) ? dat_q : {3'b000, dat_q[7:0]};
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = (state == ST_RESP) && !err_q;
`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  assign wb_err_o = (state == ST_RESP) && err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Scoreboard bench for wb_spi_bridge: directed bus cycles push expected events,
// a negedge monitor pops and compares every strobe/ack/err the DUT presents.
module tb_wb_spi_bridge;

  localparam int DW = 32;
`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  localparam int TO_CYCLES = 20;
`else
  localparam int TO_CYCLES = 4095;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]    wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [10:0]   if_din;
  logic          if_cmd, if_wr, if_rd;
  logic [8:0]    if_dout;
  logic          if_ack, if_irq;

  typedef enum int {EV_CMD, EV_WR, EV_RD, EV_ACK, EV_ERR} ev_e;
  typedef struct {
    ev_e         kind;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  bit   ack_en   = 1'b1;

`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
  localparam ev_e RSV_KIND = EV_ERR;
`else
  localparam ev_e RSV_KIND = EV_ACK;
`endif

  wb_spi_bridge #(
    .DW        (DW),
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (12)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .if_din   (if_din),
    .if_cmd   (if_cmd),
    .if_wr    (if_wr),
    .if_rd    (if_rd),
    .if_dout  (if_dout),
    .if_ack   (if_ack),
    .if_irq   (if_irq)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic void push_exp(input ev_e kind, input int cyc, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic score(input ev_e kind, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL spurious_%s: got event at cycle %0d expected none", kind.name(), cyc_cnt);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s_kind", e.kind.name()), 32'(kind), 32'(e.kind));
      check($sformatf("%s_cycle", e.kind.name()), 32'(cyc_cnt), 32'(e.cyc));
      if (e.kind != EV_ERR) check($sformatf("%s_data", e.kind.name()), data, e.data);
    end
  endtask

  // Monitor: every output event the DUT shows is matched against the queue.
  initial forever begin
    @(negedge clk);
    if (if_cmd)   score(EV_CMD, {21'b0, if_din});
    if (if_wr)    score(EV_WR,  {21'b0, if_din});
    if (if_rd)    score(EV_RD,  {21'b0, if_din});
    if (wb_ack_o) score(EV_ACK, wb_dat_o);
    if (wb_err_o) score(EV_ERR, wb_dat_o);
  end

  // Engine model: acknowledges one cycle after any strobe while ack_en is set.
  initial begin : engine
    logic s;
    forever begin
      @(negedge clk);
      s = if_cmd | if_wr | if_rd;
      @(posedge clk);
      #1;
      if (ack_en) if_ack = s;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start(input logic we, input logic [1:0] adr, input logic [31:0] dat, output int n);
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    n = cyc_cnt;
  endtask

  task automatic release_bus();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wait_resp(input int max_cyc);
    int k;
    bit got;
    k   = 0;
    got = 1'b0;
    while (!got && k < max_cyc) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) got = 1'b1;
      k++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no ack/err expected one within %0d cycles", max_cyc);
    end
    @(posedge clk);
    #1;
    release_bus();
  endtask

  // Plain request with engine idle: strobe at n+1, bus ack at n+3.
  task automatic simple(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                        input ev_e strobe, input logic [31:0] din_exp, input logic [31:0] rd_exp);
    int n;
    start(we, adr, dat, n);
    push_exp(strobe, n + 1, din_exp);
    push_exp(EV_ACK, n + 3, rd_exp);
    wait_resp(10);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wb_ack"}, 32'(wb_ack_o), 0);
    check({tag, "_wb_err"}, 32'(wb_err_o), 0);
    check({tag, "_wb_dat"}, wb_dat_o, 0);
    check({tag, "_if_cmd"}, 32'(if_cmd), 0);
    check({tag, "_if_wr"},  32'(if_wr), 0);
    check({tag, "_if_rd"},  32'(if_rd), 0);
    check({tag, "_if_din"}, 32'(if_din), 0);
  endtask

  initial begin
    int n, c;
    rst      = 1'b1;
    wb_adr_i = 2'd0;
    wb_dat_i = '0;
    if_dout  = 9'h000;
    if_ack   = 1'b0;
    if_irq   = 1'b0;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // CTRL write then read back; upper bits of a DATA write are ignored.
    simple(1'b1, 2'd0, 32'h0000_0705, EV_CMD, 32'h705, 32'h0);
    simple(1'b0, 2'd0, 32'h0,         EV_RD,  32'h0,   32'h0000_0705);
    simple(1'b1, 2'd1, 32'hFFFF_FFA5, EV_WR,  32'h0A5, 32'h0);

    // DATA write held off by busy for 50 cycles.
    if_dout = 9'h100;
    start(1'b1, 2'd1, 32'h0000_003C, n);
    repeat (50) @(posedge clk);
    #1;
    if_dout = 9'h000;
    c = cyc_cnt;
    push_exp(EV_WR,  c + 1, 32'h03C);
    push_exp(EV_ACK, c + 3, 32'h0);
    wait_resp(10);

    // STATUS and DATA reads.
    if_irq  = 1'b1;
    if_dout = 9'h15A;
    simple(1'b0, 2'd2, 32'h0, EV_RD, 32'h0, 32'h0000_0003);
    simple(1'b0, 2'd1, 32'h0, EV_RD, 32'h0, 32'h0000_005A);

    // CTRL all-ones: only 11 bits reach the engine and the shadow.
    simple(1'b1, 2'd0, 32'hFFFF_FFFF, EV_CMD, 32'h7FF, 32'h0);
    simple(1'b0, 2'd0, 32'h0,         EV_RD,  32'h0,   32'h0000_07FF);

    // Reserved address: immediate response, read data forced to 0.
    start(1'b1, 2'd3, 32'hDEAD_BEEF, n);
    push_exp(RSV_KIND, n + 1, 32'h0);
    wait_resp(5);
    start(1'b0, 2'd3, 32'h0, n);
    push_exp(RSV_KIND, n + 1, 32'h0);
    wait_resp(5);

    // Master abandons a held DATA write: no strobe, no ack.
    if_dout = 9'h1AA;
    start(1'b1, 2'd1, 32'h0000_0077, n);
    repeat (5) @(posedge clk);
    #1;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    if_dout = 9'h0C3;
    repeat (5) @(posedge clk);
    simple(1'b0, 2'd0, 32'h0, EV_RD, 32'h0, 32'h0000_07FF);

    // Master abandons during WAIT_ACK; late engine ack and a stray ack are ignored.
    ack_en = 1'b0;
    start(1'b0, 2'd1, 32'h0, n);
    push_exp(EV_RD, n + 1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    release_bus();
    repeat (3) @(posedge clk);
    #1;
    if_ack = 1'b1;
    @(posedge clk);
    #1;
    if_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if_ack = 1'b1;
    @(posedge clk);
    #1;
    if_ack = 1'b0;
    repeat (2) @(posedge clk);
    ack_en = 1'b1;
    simple(1'b0, 2'd2, 32'h0, EV_RD, 32'h0, 32'h0000_0002);
    simple(1'b0, 2'd1, 32'h0, EV_RD, 32'h0, 32'h0000_00C3);

    // Asynchronous reset while waiting for the engine clears everything.
    ack_en = 1'b0;
    start(1'b1, 2'd0, 32'h0000_0123, n);
    push_exp(EV_CMD, n + 1, 32'h123);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    release_bus();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    ack_en = 1'b1;
    simple(1'b0, 2'd0, 32'h0, EV_RD, 32'h0, 32'h0);

`ifdef WB_SPI_BRIDGE_TIMEOUT_EN
    // Engine never acks: error 20 cycles after entering WAIT_ACK.
    ack_en = 1'b0;
    start(1'b0, 2'd0, 32'h0, n);
    push_exp(EV_RD,  n + 1,  32'h0);
    push_exp(EV_ERR, n + 22, 32'h0);
    wait_resp(40);
    ack_en = 1'b1;
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
